// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared constants for the memory-side responder: MMIO register offsets,
//   STATUS register bit positions and the RISC-V NOP encoding returned for
//   instruction fetches that land in the MMIO window.
package dmem_responder_pkg;

  // MMIO register offsets, selected by addr[3:2]
  localparam logic [1:0] MMIO_TXDATA = 2'd0;
  localparam logic [1:0] MMIO_STATUS = 2'd1;
  localparam logic [1:0] MMIO_CTRL   = 2'd2;

  // STATUS register layout
  localparam int unsigned STATUS_COUNT_LSB = 0;
  localparam int unsigned STATUS_COUNT_W   = 5;
  localparam int unsigned STATUS_FULL_BIT  = 8;
  localparam int unsigned STATUS_EMPTY_BIT = 9;
  localparam int unsigned STATUS_DROP_LSB  = 16;
  localparam int unsigned DROP_W           = 8;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// dmem_responder_tx_fifo
//   Show-ahead FIFO feeding the console TX byte stream, with a saturating
//   counter of pushes that were dropped because the FIFO was full.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push_i/push_data_i  enqueue request and data
//   pop_i             consumer accepts head (ignored when empty)
//   flush_i           empty the FIFO and clear the drop counter
//   head_o/valid_o    head entry (zero when empty) and ~empty
//   count_o           occupancy 0..DEPTH
//   full_o/empty_o    occupancy flags
//   drop_cnt_o        saturating count of dropped pushes
//
// Handshake: head_o is transferred on a rising clk edge where valid_o and
// pop_i are both high; head_o does not change while valid_o is high and
// pop_i is low.
module dmem_responder_tx_fifo
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [WIDTH-1:0]  head_o,
  output logic              valid_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic do_pop;
  logic do_push;
  logic do_drop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign do_drop = push_i & full_o & ~do_pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (flush_i) begin
      // Flush wins over any pop in the same cycle.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (do_drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is not reset; the head is forced to zero while empty so stale
  // entries never appear on the output.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = ~empty_o;
  assign count_o    = count_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's instruction and data ports: a
//   dual-read word RAM with byte-lane writes plus an MMIO window holding a
//   console TX FIFO. Reads are combinational; writes and FIFO state update
//   on the rising clock edge.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   imem_addr/imem_rdata   instruction fetch address / word (NOP for MMIO)
//   dmem_addr/dmem_wdata   data address / lane-aligned store data
//   dmem_we/dmem_be        write strobe / byte enables (bit n = lane n)
//   dmem_rdata             load word, unshifted
//   tx_valid/tx_data       console byte stream, head of TX FIFO
//   tx_ready               sink accepts tx_data
//
// Address map: addr[31]=0 is RAM (word index addr[log2(RAM_WORDS)+1:2],
// upper bits alias). addr[31]=1 is MMIO with register offset addr[3:2]:
// 0 TXDATA (write pushes byte), 1 STATUS (read-only), 2 CTRL (bit0 flush),
// 3 reserved.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_rdata,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  input  logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  // Only the top address bit takes part in the RAM/MMIO decode.
  localparam logic MMIO_SEL = MMIO_BASE[31];

  logic [XLEN-1:0] ram_q [RAM_WORDS];

  logic [IDX_W-1:0] i_idx, d_idx;
  logic             i_mmio, d_mmio;
  logic [1:0]       d_off;
  logic             ram_we;
  logic             fifo_push, fifo_flush;

  logic [7:0]        fifo_head;
  logic              fifo_valid;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [DROP_W-1:0] fifo_drop;
  logic [XLEN-1:0]   status_word;

  assign i_idx  = imem_addr[IDX_W+1:2];
  assign d_idx  = dmem_addr[IDX_W+1:2];
  assign i_mmio = (imem_addr[XLEN-1] == MMIO_SEL);
  assign d_mmio = (dmem_addr[XLEN-1] == MMIO_SEL);
  assign d_off  = dmem_addr[3:2];

  assign ram_we     = dmem_we & ~d_mmio;
  assign fifo_push  = dmem_we & d_mmio & (d_off == MMIO_TXDATA) & dmem_be[0];
  assign fifo_flush = dmem_we & d_mmio & (d_off == MMIO_CTRL) & dmem_be[0]
                    & dmem_wdata[0];

  // RAM contents are deliberately not reset. Reads see the pre-edge word.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (dmem_be[n]) ram_q[d_idx][8*n +: 8] <= dmem_wdata[8*n +: 8];
      end
    end
  end

  dmem_responder_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i (dmem_wdata[7:0]),
    .pop_i       (tx_ready),
    .flush_i     (fifo_flush),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_cnt_o  (fifo_drop)
  );

  assign tx_valid = fifo_valid;
  assign tx_data  = fifo_head;

  always_comb begin
    status_word = '0;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    status_word[STATUS_FULL_BIT]                    = fifo_full;
    status_word[STATUS_EMPTY_BIT]                   = fifo_empty;
    status_word[STATUS_DROP_LSB +: DROP_W]          = fifo_drop;
  end

  always_comb begin
    dmem_rdata = '0;
    if (!d_mmio) begin
      dmem_rdata = ram_q[d_idx];
    end else if (d_off == MMIO_STATUS) begin
      dmem_rdata = status_word;
    end
  end

  assign imem_rdata = i_mmio ? XLEN'(RV_NOP) : ram_q[i_idx];

  // Address bits outside the decode are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[XLEN-2:IDX_W+2], imem_addr[1:0],
                              dmem_addr[XLEN-2:IDX_W+2], dmem_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WORDS = 1024;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  dmem_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];       // bytes queued for the console, oldest first
  int          drops;
  logic [31:0] ram_m  [WORDS];
  bit          ram_ok [WORDS];
  bit          chk_en;

  int n_cmp;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(exp_q.size());
    if (exp_q.size() == DEPTH) s = s + 32'h100;
    if (exp_q.size() == 0)     s = s + 32'h200;
    s = s + (32'(drops) << 16);
    return s;
  endfunction

  // Compare the combinational outputs, then advance the model by the edge
  // that the currently applied inputs will see.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      int idx;
      bit push, flush, pop;
      check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q[0]));
      if (imem_addr[31]) check("imem_nop", imem_rdata, 32'h13);
      else begin
        idx = int'(imem_addr[11:2]);
        if (ram_ok[idx]) check("imem_ram", imem_rdata, ram_m[idx]);
      end
      if (!dmem_addr[31]) begin
        idx = int'(dmem_addr[11:2]);
        if (ram_ok[idx]) check("dmem_ram", dmem_rdata, ram_m[idx]);
      end else if (dmem_addr[3:2] == 2'd1) check("dmem_status", dmem_rdata, model_status());
      else check("dmem_mmio_zero", dmem_rdata, 32'h0);

      pop   = tx_ready && (exp_q.size() != 0);
      push  = dmem_we && dmem_addr[31] && dmem_addr[3:2] == 2'd0 && dmem_be[0];
      flush = dmem_we && dmem_addr[31] && dmem_addr[3:2] == 2'd2 && dmem_be[0] && dmem_wdata[0];
      if (flush) begin
        exp_q.delete();
        drops = 0;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (push) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(dmem_wdata[7:0]);
          else if (drops < 255) drops++;
        end
      end
      if (dmem_we && !dmem_addr[31]) begin
        idx = int'(dmem_addr[11:2]);
        for (int n = 0; n < 4; n++)
          if (dmem_be[n]) ram_m[idx][8*n +: 8] = dmem_wdata[8*n +: 8];
        // Partially written words are only trusted once fully known.
        if (dmem_be == 4'hF) ram_ok[idx] = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    dmem_we    = 1'b0;
    dmem_be    = 4'h0;
    dmem_wdata = 32'h0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_be    = be;
    dmem_we    = 1'b1;
    step();
    set_idle();
  endtask

  task automatic read_at_neg(input logic [31:0] da, input logic [31:0] ia);
    dmem_addr = da;
    imem_addr = ia;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_fail = 0; drops = 0; chk_en = 1'b0;
    reset_n = 1'b0; tx_ready = 1'b0;
    imem_addr = 32'h0; dmem_addr = 32'h8000_0004;
    set_idle();
    #2;
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    step();
    chk_en = 1'b1;
    read_at_neg(32'h8000_0004, 32'h8000_0000);
    check("reset_status", dmem_rdata, 32'h0000_0200);
    check("imem_mmio_nop", imem_rdata, 32'h0000_0013);
    step();

    // byte-lane merge
    dwrite(32'h10, 32'hDEAD_BEEF, 4'hF);
    dwrite(32'h10, 32'h0000_5500, 4'b0010);
    read_at_neg(32'h10, 32'h10);
    check("lane_merge_d", dmem_rdata, 32'hDEAD_55EF);
    check("lane_merge_i", imem_rdata, 32'hDEAD_55EF);
    step();

    // aliasing modulo RAM size
    dwrite(32'h0000_1004, 32'h1234_5678, 4'hF);
    read_at_neg(32'h4, 32'h0000_2004);
    check("wrap_d", dmem_rdata, 32'h1234_5678);
    check("wrap_i", imem_rdata, 32'h1234_5678);
    step();

    // overflow with sink stalled
    for (int i = 0; i < 10; i++) dwrite(32'h8000_0000, 32'(8'h41 + i), 4'h1);
    read_at_neg(32'h8000_0004, 32'h0);
    check("status_overflow", dmem_rdata, 32'h0002_0108);
    step();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_byte", 32'(tx_data), 32'(8'h41 + i));
      step();
    end
    @(negedge clk);
    check("drain_empty_valid", 32'(tx_valid), 32'h0);
    check("drain_empty_bit", 32'(dmem_rdata[9]), 32'h1);
    step();

    // push into full FIFO while the head leaves
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) dwrite(32'h8000_0000, 32'(8'h50 + i), 4'h1);
    tx_ready = 1'b1;
    dwrite(32'h8000_0000, 32'h5A, 4'h1);
    tx_ready = 1'b0;
    read_at_neg(32'h8000_0004, 32'h0);
    check("full_push_pop", dmem_rdata, 32'h0002_0108);
    step();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("full_push_order", 32'(tx_data), (i == 7) ? 32'h5A : 32'(8'h51 + i));
      step();
    end
    tx_ready = 1'b0;

    // drop counter saturation, then flush
    for (int i = 0; i < 300; i++) dwrite(32'h8000_0000, 32'(i), 4'h1);
    read_at_neg(32'h8000_0004, 32'h0);
    check("drop_saturate", dmem_rdata, 32'h00FF_0108);
    step();
    dwrite(32'h8000_0008, 32'h1, 4'h1);
    read_at_neg(32'h8000_0004, 32'h0);
    check("after_flush", dmem_rdata, 32'h0000_0200);
    step();

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) dwrite(32'h8000_0000, 32'(8'h61 + i), 4'h1);
    @(negedge clk);
    check("pre_reset_valid", 32'(tx_valid), 32'h1);
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(tx_valid), 32'h0);
    exp_q.delete();
    drops = 0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    step();
    chk_en = 1'b1;
    read_at_neg(32'h10, 32'h4);
    check("ram_kept_d", dmem_rdata, 32'hDEAD_55EF);
    check("ram_kept_i", imem_rdata, 32'h1234_5678);
    step();

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] ra;
      r = int'($urandom_range(0, 99));
      tx_ready = ($urandom_range(0, 2) != 0);
      ra = {1'b0, 19'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)};
      imem_addr = ($urandom_range(0, 9) == 0) ? {1'b1, 31'($urandom)}
                : {1'b0, 19'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)};
      if (r < 30) begin
        dmem_addr = ra; dmem_wdata = $urandom; dmem_be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
        dmem_we = 1'b1;
      end else if (r < 60) begin
        dmem_addr = {1'b1, 27'($urandom), 2'd0, 2'($urandom)};
        dmem_wdata = $urandom; dmem_be = 4'($urandom); dmem_we = 1'b1;
      end else if (r < 63) begin
        dmem_addr = {1'b1, 27'($urandom), 2'd2, 2'($urandom)};
        dmem_wdata = $urandom; dmem_be = 4'($urandom); dmem_we = 1'b1;
      end else if (r < 68) begin
        dmem_addr = {1'b1, 27'($urandom), ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd3, 2'($urandom)};
        dmem_wdata = $urandom; dmem_be = 4'($urandom); dmem_we = 1'b1;
      end else begin
        set_idle();
        dmem_addr = ($urandom_range(0, 1) != 0) ? ra : {1'b1, 27'($urandom), 2'($urandom), 2'($urandom)};
      end
      step();
    end
    set_idle();
    tx_ready = 1'b0;
    step();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's instruction and data ports.
- Holds a dual-read word RAM with byte-lane writes and a small MMIO region.
- The MMIO region contains a console TX FIFO that drains over a valid/ready byte stream.
- Reads are combinational, so the core's single-cycle fetch/load timing holds; writes and FIFO state update on the clock edge.

Parameters:
- XLEN, 32, data/address width.
- RAM_WORDS, 1024, RAM depth in 32-bit words; must be a power of two.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..16.
- MMIO_BASE, 32'h8000_0000, base of MMIO region; only bit 31 is decoded.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- imem_addr  input  XLEN  instruction fetch byte address
- imem_rdata  output  XLEN  instruction word
- dmem_addr  input  XLEN  data byte address
- dmem_wdata  input  XLEN  store data, already lane-aligned
- dmem_we  input  1  write strobe
- dmem_be  input  4  byte enables, bit n = byte lane n
- dmem_rdata  output  XLEN  load word, unshifted
- tx_valid  output  1  FIFO head byte available
- tx_data  output  8  FIFO head byte
- tx_ready  input  1  sink accepts tx_data

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - FIFO pointers, count and drop_cnt cleared.
  - tx_valid=0, tx_data=0.
  - RAM contents are not reset.
  - imem_rdata/dmem_rdata remain combinational functions of address and state.
- Address decode:
  - Bit 31 = 0 selects RAM. Word index = addr[log2(RAM_WORDS)+1:2].
  - Upper RAM address bits are ignored, so accesses alias and wrap modulo RAM size.
  - addr[1:0] is ignored for indexing.
- RAM read:
  - imem_rdata = RAM[imem index], same cycle.
  - dmem_rdata = RAM[dmem index], same cycle.
  - imem_addr with bit 31 = 1 returns 32'h0000_0013 (NOP).
- RAM write:
  - At posedge clk, when dmem_we=1 and RAM is selected, each lane n with dmem_be[n]=1 takes dmem_wdata[8n+7:8n].
  - Lanes with dmem_be[n]=0 are unchanged.
  - A read in the same cycle returns the old word (no write-through).
- MMIO (bit 31 = 1), register offset = addr[3:2]:
  - Offset 0, TXDATA: a write with be[0]=1 pushes wdata[7:0]. Reads return 0.
  - Offset 1, STATUS (read-only):
    - bits[4:0] = count.
    - bit 8 = full.
    - bit 9 = empty.
    - bits[23:16] = drop_cnt.
    - All other bits are 0. Writes are ignored.
  - Offset 2, CTRL: a write with wdata[0]=1 and be[0]=1 flushes the FIFO and clears drop_cnt. Reads return 0.
  - Offset 3: reads return 0, writes are ignored.
- FIFO:
  - Show-ahead: tx_data = head entry, tx_valid = ~empty.
  - Pop occurs when tx_valid & tx_ready at posedge.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
- Push when full:
  - If no pop happens that cycle, the byte is dropped and drop_cnt increments, saturating at 255.
  - If a pop happens the same cycle, the push is accepted and count is unchanged.
- Push and pop when not full: both take effect; count unchanged.
- Flush:
  - Pointers and count go to 0 next cycle.
  - A simultaneous pop is absorbed; no double decrement.
- Pointer arithmetic: pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Reset mid-operation: FIFO empties immediately (asynchronous). Queued bytes are lost; RAM is retained.
- Latency:
  - Push to tx_valid: 1 cycle.
  - Load/fetch: 0 cycles.

Decomposition:
- In constants.vh:
  - MMIO offsets: MMIO_TXDATA, MMIO_STATUS, MMIO_CTRL.
  - STATUS bit positions.
  - RV_NOP (already present).
- Sub-module tx_fifo: parameterised depth and width, with push/pop/flush, count, full, empty, drop counter.
- Decode, RAM and register read mux stay in dmem_responder.

Test Plan:
- Write 32'hDEAD_BEEF to 0x10 with be=4'hF, then be=4'b0010 with wdata=32'h0000_5500 -> dmem_rdata at 0x10 = 32'hDEAD_55EF; imem_addr=0x10 also returns 32'hDEAD_55EF.
- RAM_WORDS=1024: write 32'h1234_5678 to 0x0000_1004 -> reading 0x0000_0004 returns 32'h1234_5678 (wrap).
- With tx_ready=0, push 0x41..0x4A (10 bytes, FIFO_DEPTH=8) -> STATUS = 32'h0002_0108. Then tx_ready=1 -> tx_data sequence 0x41..0x48, then tx_valid=0 and STATUS bit 9 set.
- FIFO full and tx_ready=1: push 0x5A in the same cycle -> count stays 8, drop_cnt unchanged, 0x5A emerges last.
- 300 pushes into a full FIFO with tx_ready=0 -> drop_cnt = 255; then write CTRL=1 -> STATUS = 32'h0000_0200.
- Assert reset_n=0 mid-stream with 3 bytes queued -> tx_valid falls without waiting for clk; RAM word written earlier still reads back after release.
